// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler
//   Sequencer and arbiter for the single shared barrier gate of the parking
//   lot. It grants the gate to the entry or exit requester, times the open
//   window with the 1 Hz tick, tracks lot occupancy, and emits a one-cycle
//   full_trigger pulse for the full-lot flasher. Single 40 MHz clock domain.
//
// Optional feature macro: PARK_GATE_TIMEOUT_EN
//   defined   : the open window expires after GATE_TICKS ticks (timeout pulse).
//   undefined : no timer; the gate leaves OPEN only on car_passed, timeout = 0,
//               tick is ignored.
//
// Parameters
//   CAPACITY   lot size (1 .. 2**CNT_W-1)
//   CNT_W      occupancy counter width
//   GATE_TICKS ticks the gate waits for a car (1 .. 15)
//
// Ports
//   clk_40MHz    in   system clock
//   reset_n      in   asynchronous active-low reset
//   tick         in   one-cycle pulse, once per second
//   entry_req    in   level, car waiting at entry
//   exit_req     in   level, car waiting at exit
//   car_passed   in   one-cycle pulse from the gate-line sensor
//   gate_open    out  barrier raised
//   gate_dir     out  1 = entry, 0 = exit (valid while gate_open)
//   entry_grant  out  one-cycle pulse on an entry grant
//   exit_grant   out  one-cycle pulse on an exit grant
//   occupancy    out  cars inside
//   full         out  occupancy == CAPACITY
//   full_trigger out  one-cycle pulse to the flasher
//   timeout      out  one-cycle pulse when an open window expires unused
module parking_gate_scheduler #(
  parameter int CAPACITY   = 8,
  parameter int CNT_W      = 4,
  parameter int GATE_TICKS = 3
) (
  input  logic             clk_40MHz,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             gate_open,
  output logic             gate_dir,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             full_trigger,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPEN_IN,
    ST_OPEN_OUT,
    ST_CLOSE
  } state_t;

  localparam logic [CNT_W-1:0] LP_CAP = CNT_W'(CAPACITY);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_occ;
  logic             r_last_dir;     // 1 = last grant was entry
  logic             r_entry_d;      // entry_req edge-detect register
  logic             r_trig_pend;    // entry_req rose while full
  logic             r_entry_grant;
  logic             r_exit_grant;
  logic             r_full_trigger;
  logic             r_timeout;

  logic w_full;
  logic w_empty;
  logic w_entry_ok;
  logic w_exit_ok;
  logic w_grant_in;
  logic w_grant_out;
  logic w_inc;
  logic w_dec;
  logic w_expire;
  logic w_tick_last;
  logic w_full_hit;
  logic w_rise;

  // Saturating occupancy arithmetic; grants already keep the count in range,
  // so saturation only guards against inconsistent sensor pulses.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LP_CAP) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  assign w_full     = (r_occ == LP_CAP);
  assign w_empty    = (r_occ == '0);
  assign w_entry_ok = entry_req && !w_full;
  assign w_exit_ok  = exit_req && !w_empty;
  assign w_rise     = entry_req && !r_entry_d;
  assign w_full_hit = w_inc && !w_full && (sat_inc(r_occ) == LP_CAP);

`ifdef PARK_GATE_TIMEOUT_EN
  logic [3:0] r_timer;

  assign w_tick_last = tick && (r_timer == 4'd1);

  always_ff @(posedge clk_40MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= 4'd0;
    end else if (w_grant_in || w_grant_out) begin
      r_timer <= 4'(GATE_TICKS);
    end else if ((r_state == ST_OPEN_IN || r_state == ST_OPEN_OUT) &&
                 !car_passed && tick && (r_timer != 4'd0)) begin
      r_timer <= r_timer - 4'd1;
    end
  end
`else
  logic w_unused_tick;

  assign w_unused_tick = tick;
  assign w_tick_last   = 1'b0;
`endif

  // Next-state and per-cycle event decode
  always_comb begin
    w_state_nxt = r_state;
    w_grant_in  = 1'b0;
    w_grant_out = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Under contention the direction opposite to the last grant wins.
        if (w_entry_ok && (!w_exit_ok || !r_last_dir)) begin
          w_grant_in  = 1'b1;
          w_state_nxt = ST_OPEN_IN;
        end else if (w_exit_ok) begin
          w_grant_out = 1'b1;
          w_state_nxt = ST_OPEN_OUT;
        end
      end
      ST_OPEN_IN, ST_OPEN_OUT: begin
        // A pass beats a coincident final tick.
        if (car_passed) begin
          w_inc       = (r_state == ST_OPEN_IN);
          w_dec       = (r_state == ST_OPEN_OUT);
          w_state_nxt = ST_CLOSE;
        end else if (w_tick_last) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_CLOSE;
        end
      end
      ST_CLOSE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered state, counters and output pulses
  always_ff @(posedge clk_40MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_occ          <= '0;
      r_last_dir     <= 1'b0;
      r_entry_d      <= 1'b0;
      r_trig_pend    <= 1'b0;
      r_entry_grant  <= 1'b0;
      r_exit_grant   <= 1'b0;
      r_full_trigger <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_entry_grant  <= w_grant_in;
      r_exit_grant   <= w_grant_out;
      r_timeout      <= w_expire;
      r_entry_d      <= entry_req;
      r_trig_pend    <= w_rise && w_full;
      // Fill event and a delayed re-request share one pulse when coincident.
      r_full_trigger <= w_full_hit || r_trig_pend;
      if (w_grant_in || w_grant_out) begin
        r_last_dir <= w_grant_in;
      end
      if (w_inc) begin
        r_occ <= sat_inc(r_occ);
      end else if (w_dec) begin
        r_occ <= sat_dec(r_occ);
      end
    end
  end

  assign gate_open    = (r_state == ST_OPEN_IN) || (r_state == ST_OPEN_OUT);
  assign gate_dir     = (r_state == ST_OPEN_IN);
  assign entry_grant  = r_entry_grant;
  assign exit_grant   = r_exit_grant;
  assign occupancy    = r_occ;
  assign full         = w_full;
  assign full_trigger = r_full_trigger;
  assign timeout      = r_timeout;

endmodule
